// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for the two-stage pipelined ALU.
// The master side drives operands and accepts results; the slave side is the ALU.
interface alu_pipe_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [3:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_c;
  logic         out_v;
  logic         out_z;
  logic         out_n;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_y, out_c, out_v, out_z, out_n
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_y, out_c, out_v, out_z, out_n
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// Stage 1 captures operands; stage 2 holds the computed result and flags.
// Optional build macro ALU_SAT_EN: ADD saturates to all-ones on carry and SUB
// clamps to zero on borrow (c/v still describe the unsaturated result).
module alu_pipe #(
  parameter int W = 8
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);
  localparam int SHW = $clog2(W) + 1;
  localparam logic [SHW-1:0] W_SH = SHW'(W);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_XNOR = 4'd5,
    OP_NOT  = 4'd6,
    OP_SHR  = 4'd7,
    OP_SHL  = 4'd8
  } op_e;

  logic [W-1:0] a_q, b_q;
  logic [3:0]   op_q;
  logic         s1Valid_q;

  logic [W-1:0] y_q;
  logic         c_q, v_q, z_q, n_q;
  logic         s2Valid_q;

  logic [W-1:0] y_d, rawY;
  logic         c_d, v_d, z_d, n_d;

  logic         s2Free, inFire, s1Advance;
  logic [W:0]   sum, diff;
  logic         bigShift;

  assign s2Free    = !s2Valid_q || bus.out_ready;
  assign bus.in_ready = !s1Valid_q || s2Free;
  assign inFire    = bus.in_valid && bus.in_ready;
  assign s1Advance = s1Valid_q && s2Free;

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  // Any shift amount of W or more (looking at b's full value) empties the word.
  assign bigShift = (|(b_q >> SHW)) || (b_q[SHW-1:0] >= W_SH);

  assign bus.out_valid = s2Valid_q;
  assign bus.out_y     = y_q;
  assign bus.out_c     = c_q;
  assign bus.out_v     = v_q;
  assign bus.out_z     = z_q;
  assign bus.out_n     = n_q;

  // Stage 1 operand register: load on an accepted beat, empty when handed to stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
    end else if (inFire) begin
      s1Valid_q <= 1'b1;
      a_q       <= bus.in_a;
      b_q       <= bus.in_b;
      op_q      <= bus.in_op;
    end else if (s1Advance) begin
      s1Valid_q <= 1'b0;
    end
  end

  // Result and flag computation from the stage 1 registers.
  always_comb begin
    rawY = '0;
    y_d  = '0;
    c_d  = 1'b0;
    v_d  = 1'b0;
    case (op_q)
      OP_ADD: begin
        rawY = sum[W-1:0];
        c_d  = sum[W];
        v_d  = (a_q[W-1] == b_q[W-1]) && (rawY[W-1] != a_q[W-1]);
`ifdef ALU_SAT_EN
        y_d  = sum[W] ? {W{1'b1}} : rawY;
`else
        y_d  = rawY;
`endif
      end
      OP_SUB: begin
        rawY = diff[W-1:0];
        c_d  = diff[W];
        v_d  = (a_q[W-1] != b_q[W-1]) && (rawY[W-1] != a_q[W-1]);
`ifdef ALU_SAT_EN
        y_d  = diff[W] ? '0 : rawY;
`else
        y_d  = rawY;
`endif
      end
      OP_AND:  y_d = a_q & b_q;
      OP_OR:   y_d = a_q | b_q;
      OP_XOR:  y_d = a_q ^ b_q;
      OP_XNOR: y_d = ~(a_q ^ b_q);
      OP_NOT:  y_d = ~a_q;
      OP_SHR:  y_d = bigShift ? '0 : (a_q >> b_q[SHW-1:0]);
      OP_SHL:  y_d = bigShift ? '0 : (a_q << b_q[SHW-1:0]);
      default: y_d = '0;
    endcase
    z_d = (y_d == '0);
    n_d = y_d[W-1];
  end

  // Stage 2 result register: refill whenever the downstream slot is free, hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      y_q       <= '0;
      c_q       <= 1'b0;
      v_q       <= 1'b0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
    end else if (s2Free) begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        y_q <= y_d;
        c_q <= c_d;
        v_q <= v_d;
        z_q <= z_d;
        n_q <= n_d;
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors at W=4 and W=16,
// a backpressured stream and an asynchronous reset with both stages full.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_pipe_if #(.W(4))  bus4 ();
  alu_pipe_if #(.W(16)) bus16 ();

  alu_pipe #(.W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  alu_pipe #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [19:0] expected;
  } vec_t;

  vec_t vecs [20];

  function automatic logic [19:0] pk4(logic [3:0] y, logic c, logic v, logic z, logic n);
    return {12'd0, y, c, v, z, n};
  endfunction

  function automatic logic [19:0] pk16(logic [15:0] y, logic c, logic v, logic z, logic n);
    return {y, c, v, z, n};
  endfunction

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [19:0] actual, input logic [19:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Present one beat (starting at a falling edge) and hold it until accepted.
  task automatic applyStimulus(input bit wide, input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    int n;
    n = 0;
    if (wide) begin
      bus16.in_a = a; bus16.in_b = b; bus16.in_op = op; bus16.in_valid = 1'b1;
    end else begin
      bus4.in_a = a[3:0]; bus4.in_b = b[3:0]; bus4.in_op = op; bus4.in_valid = 1'b1;
    end
    #1;
    while (!(wide ? bus16.in_ready : bus4.in_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept timeout: in_ready low for %0d cycles, required high", n);
    end
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus4.in_valid  = 1'b0;
  endtask

  // Send one beat, check its latency, its result/flags and that it leaves exactly once.
  task automatic runVector(input string name, input bit wide, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] op, input logic [19:0] expected);
    logic [19:0] res;
    int lat;
    applyStimulus(wide, a, b, op);
    lat = 0;
    while (!(wide ? bus16.out_valid : bus4.out_valid) && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    checkOutput({name, " latency"}, 20'(lat), 20'd1);
    res = wide ? {bus16.out_y, bus16.out_c, bus16.out_v, bus16.out_z, bus16.out_n}
               : {12'd0, bus4.out_y, bus4.out_c, bus4.out_v, bus4.out_z, bus4.out_n};
    checkOutput(name, res, expected);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " drained"}, 20'(wide ? bus16.out_valid : bus4.out_valid), 20'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int got, sent, lowCnt, stallCnt;
    logic inFire;
    logic [3:0] held;

    vecs[0]  = '{"add F+1",   4'd0,  4'hF, 4'h1, pk4(4'h0, 1, 0, 1, 0)};
    vecs[1]  = '{"sub 3-5",   4'd1,  4'h3, 4'h5, pk4(4'hE, 1, 0, 0, 1)};
    vecs[16] = '{"add 8+8",   4'd0,  4'h8, 4'h8, pk4(4'h0, 1, 1, 1, 0)};
`ifdef ALU_SAT_EN
    vecs[0]  = '{"add F+1",   4'd0,  4'hF, 4'h1, pk4(4'hF, 1, 0, 0, 1)};
    vecs[1]  = '{"sub 3-5",   4'd1,  4'h3, 4'h5, pk4(4'h0, 1, 0, 1, 0)};
    vecs[16] = '{"add 8+8",   4'd0,  4'h8, 4'h8, pk4(4'hF, 1, 1, 0, 1)};
`endif
    vecs[2]  = '{"add 7+1",   4'd0,  4'h7, 4'h1, pk4(4'h8, 0, 1, 0, 1)};
    vecs[3]  = '{"shl 3<<2",  4'd8,  4'h3, 4'h2, pk4(4'hC, 0, 0, 0, 1)};
    vecs[4]  = '{"shr 8>>4",  4'd7,  4'h8, 4'h4, pk4(4'h0, 0, 0, 1, 0)};
    vecs[5]  = '{"shl 1<<F",  4'd8,  4'h1, 4'hF, pk4(4'h0, 0, 0, 1, 0)};
    vecs[6]  = '{"op 12",     4'd12, 4'h7, 4'h3, pk4(4'h0, 0, 0, 1, 0)};
    vecs[7]  = '{"and C,A",   4'd2,  4'hC, 4'hA, pk4(4'h8, 0, 0, 0, 1)};
    vecs[8]  = '{"or C,A",    4'd3,  4'hC, 4'hA, pk4(4'hE, 0, 0, 0, 1)};
    vecs[9]  = '{"xor C,A",   4'd4,  4'hC, 4'hA, pk4(4'h6, 0, 0, 0, 0)};
    vecs[10] = '{"xnor C,A",  4'd5,  4'hC, 4'hA, pk4(4'h9, 0, 0, 0, 1)};
    vecs[11] = '{"not 5",     4'd6,  4'h5, 4'h0, pk4(4'hA, 0, 0, 0, 1)};
    vecs[12] = '{"shr C>>2",  4'd7,  4'hC, 4'h2, pk4(4'h3, 0, 0, 0, 0)};
    vecs[13] = '{"shl 1<<3",  4'd8,  4'h1, 4'h3, pk4(4'h8, 0, 0, 0, 1)};
    vecs[14] = '{"sub 5-5",   4'd1,  4'h5, 4'h5, pk4(4'h0, 0, 0, 1, 0)};
    vecs[15] = '{"sub 8-1",   4'd1,  4'h8, 4'h1, pk4(4'h7, 0, 1, 0, 0)};
    vecs[17] = '{"op 15",     4'd15, 4'hF, 4'hF, pk4(4'h0, 0, 0, 1, 0)};
    vecs[18] = '{"add 2+3",   4'd0,  4'h2, 4'h3, pk4(4'h5, 0, 0, 0, 0)};
    vecs[19] = '{"shr 8>>3",  4'd7,  4'h8, 4'h3, pk4(4'h1, 0, 0, 0, 0)};

    rst = 1'b1;
    bus4.in_valid = 1'b0;  bus4.in_a = '0;  bus4.in_b = '0;  bus4.in_op = '0;  bus4.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_a = '0; bus16.in_b = '0; bus16.in_op = '0; bus16.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset outputs", {11'd0, bus4.out_valid, bus4.out_y, bus4.out_c, bus4.out_v, bus4.out_z, bus4.out_n}, 20'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready after reset", 20'(bus4.in_ready), 20'd1);

    // Directed W=4 table.
    for (int i = 0; i < 20; i++) begin
      runVector(vecs[i].name, 1'b0, {12'd0, vecs[i].a}, {12'd0, vecs[i].b}, vecs[i].op, vecs[i].expected);
    end

    // W=16 arithmetic and shift corners.
    runVector("w16 add 7FFF+1", 1'b1, 16'h7FFF, 16'h0001, 4'd0, pk16(16'h8000, 0, 1, 0, 1));
`ifdef ALU_SAT_EN
    runVector("w16 sub 0-1",    1'b1, 16'h0000, 16'h0001, 4'd1, pk16(16'h0000, 1, 0, 1, 0));
    runVector("w16 add FFFF+1", 1'b1, 16'hFFFF, 16'h0001, 4'd0, pk16(16'hFFFF, 1, 0, 0, 1));
`else
    runVector("w16 sub 0-1",    1'b1, 16'h0000, 16'h0001, 4'd1, pk16(16'hFFFF, 1, 0, 0, 1));
    runVector("w16 add FFFF+1", 1'b1, 16'hFFFF, 16'h0001, 4'd0, pk16(16'h0000, 1, 0, 1, 0));
`endif
    runVector("w16 sub 8000-1", 1'b1, 16'h8000, 16'h0001, 4'd1, pk16(16'h7FFF, 0, 1, 0, 0));
    runVector("w16 shl 1<<16",  1'b1, 16'h0001, 16'h0010, 4'd8, pk16(16'h0000, 0, 0, 1, 0));
    runVector("w16 shl 1<<15",  1'b1, 16'h0001, 16'h000F, 4'd8, pk16(16'h8000, 0, 0, 0, 1));
    runVector("w16 shr b=100",  1'b1, 16'h8000, 16'h0100, 4'd7, pk16(16'h0000, 0, 0, 1, 0));
    runVector("w16 shr FFFF>>4", 1'b1, 16'hFFFF, 16'h0004, 4'd7, pk16(16'h0FFF, 0, 0, 0, 0));

    // Six back-to-back beats (a=i, b=1, ADD) with out_ready low for cycles 3..5.
    got = 0; sent = 0; lowCnt = 0; stallCnt = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      bus4.out_ready = !(cyc >= 3 && cyc < 6);
      if (sent < 6) begin
        bus4.in_valid = 1'b1; bus4.in_a = sent[3:0]; bus4.in_b = 4'h1; bus4.in_op = 4'd0;
      end else begin
        bus4.in_valid = 1'b0;
      end
      #1;
      inFire = bus4.in_valid && bus4.in_ready;
      if (!bus4.in_ready) lowCnt++;
      if (bus4.out_valid && !bus4.out_ready) begin
        if (stallCnt > 0) checkOutput($sformatf("stall hold %0d", stallCnt), 20'(bus4.out_y), 20'(held));
        held = bus4.out_y;
        stallCnt++;
      end
      if (bus4.out_valid && bus4.out_ready) begin
        checkOutput($sformatf("stream beat %0d", got), 20'(bus4.out_y), 20'(got + 1));
        got++;
      end
      @(posedge clk);
      if (inFire) sent++;
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    checkOutput("stream results", 20'(got), 20'd6);
    checkOutput("stream in_ready low cycles", 20'(lowCnt), 20'd3);
    checkOutput("stream stalled cycles", 20'(stallCnt), 20'd3);
    repeat (2) @(negedge clk);
    checkOutput("stream no duplicate", 20'(bus4.out_valid), 20'd0);

    // Fill both stages under backpressure, then reset asynchronously mid-cycle.
    bus4.out_ready = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_a = 4'h1; bus4.in_b = 4'h1; bus4.in_op = 4'd0;
    @(posedge clk); @(negedge clk);
    bus4.in_a = 4'h2; bus4.in_b = 4'h2;
    @(posedge clk); @(negedge clk);
    bus4.in_valid = 1'b0;
    #1;
    checkOutput("both stages full", {18'd0, bus4.out_valid, bus4.in_ready}, 20'b10);
    checkOutput("full stage y", 20'(bus4.out_y), 20'h2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset outputs", {11'd0, bus4.out_valid, bus4.out_y, bus4.out_c, bus4.out_v, bus4.out_z, bus4.out_n}, 20'd0);
    @(negedge clk);
    rst = 1'b0;
    bus4.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput($sformatf("dropped beat %0d", k), 20'(bus4.out_valid), 20'd0);
    end
    runVector("after reset add 3+4", 1'b0, 16'h0003, 16'h0004, 4'd0, pk4(4'h7, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
